// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_hs
// Description : Elastic pipeline register with a valid/ready handshake.
//               SKID=1 gives a two-entry skid buffer (main + skid register)
//               with a registered in_ready and full throughput.
//               SKID=0 gives a single-entry stage whose in_ready depends
//               combinationally on out_ready.
//               Both modes support flush and a global hold, and both keep
//               beats in order.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flush           - drop every held and incoming beat
//               hold            - freeze: no accept, no drain
//               in_valid/in_ready/in_data    - upstream handshake
//               out_valid/out_ready/out_data - downstream handshake
//               count           - number of held entries (0..2 or 0..1)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam logic [1:0] c_max_count = (SKID != 0) ? 2'd2 : 2'd1;

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [1:0]       count_q,      count_d;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready;
  assign pop  = main_valid_q & out_ready & ~hold;

  // --------------------------------------------------------------------------
  // Mode-specific storage and in_ready
  // --------------------------------------------------------------------------
  generate
    if (SKID != 0) begin : g_skid
      // skid_valid_q is a flop, so hold is the only combinational input here.
      assign in_ready = ~skid_valid_q & ~hold;

      always_ff @(posedge clk) begin
        if (rst) begin
          skid_valid_q <= 1'b0;
          skid_data_q  <= RESET_VAL;
        end else begin
          skid_valid_q <= skid_valid_d;
          skid_data_q  <= skid_data_d;
        end
      end
    end else begin : g_single
      // A pop this cycle frees the single entry, allowing pass-through refill.
      assign in_ready     = (~main_valid_q | out_ready) & ~hold;
      assign skid_valid_q = 1'b0;
      assign skid_data_q  = RESET_VAL;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // The upstream stage is flushed as well, so a same-cycle push is dropped.
      main_valid_d = 1'b0;
      main_data_d  = RESET_VAL;
      skid_valid_d = 1'b0;
      skid_data_d  = RESET_VAL;
    end else if (pop && skid_valid_q) begin
      // in_ready is low whenever skid is full, so no push can coincide.
      main_valid_d = 1'b1;
      main_data_d  = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (push && (!main_valid_q || pop)) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end else if (push) begin
      // Main is occupied and stalled: park the beat in the skid register.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end else if (pop) begin
      // Data is intentionally left in place on a plain pop.
      main_valid_d = 1'b0;
    end

    count_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RESET_VAL;
      count_q      <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      count_q      <= count_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign count     = count_q;

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_out_stable: assert property (@(posedge clk)
    (!rst && out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  a_count_max: assert property (@(posedge clk) count_q <= c_max_count);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_hs
// Description : Self-checking bench for pipe_stage_hs. One instance per mode
//               (SKID=1 and SKID=0) shares the same stimulus; each is compared
//               every cycle against a queue-based model of its stage, with a
//               few hand-computed expectations on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             hold;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;

  logic             in_ready1,  in_ready0;
  logic             out_valid1, out_valid0;
  logic [WIDTH-1:0] out_data1,  out_data0;
  logic [1:0]       count1,     count0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.WIDTH(WIDTH), .SKID(1), .RESET_VAL('0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count(count1)
  );

  pipe_stage_hs #(.WIDTH(WIDTH), .SKID(0), .RESET_VAL('0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .count(count0)
  );

  // Model state: FIFO of held beats plus the last value shown on out_data.
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] last1, last0;
  int               checks = 0;
  int               errors = 0;
  bit               cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready1();
    return !hold && (q1.size() < 2);
  endfunction

  function automatic logic exp_ready0();
    return !hold && ((q0.size() == 0) || out_ready);
  endfunction

  // Compare both DUTs with the model, then advance the model at the edge.
  task automatic step();
    logic r1, r0, pu1, pu0, po1, po0;
    @(negedge clk);
    if (cmp_en) begin
      chk("m1_out_valid", {31'd0, out_valid1}, {31'd0, q1.size() > 0});
      chk("m1_out_data",  out_data1, (q1.size() > 0) ? q1[0] : last1);
      chk("m1_count",     {30'd0, count1}, q1.size());
      chk("m0_out_valid", {31'd0, out_valid0}, {31'd0, q0.size() > 0});
      chk("m0_out_data",  out_data0, (q0.size() > 0) ? q0[0] : last0);
      chk("m0_count",     {30'd0, count0}, q0.size());
      if (!rst) begin
        chk("m1_in_ready", {31'd0, in_ready1}, {31'd0, exp_ready1()});
        chk("m0_in_ready", {31'd0, in_ready0}, {31'd0, exp_ready0()});
      end
    end
    @(posedge clk);
    r1  = exp_ready1();
    r0  = exp_ready0();
    pu1 = in_valid && r1;
    pu0 = in_valid && r0;
    po1 = (q1.size() > 0) && out_ready && !hold;
    po0 = (q0.size() > 0) && out_ready && !hold;
    if (rst || flush) begin
      q1.delete(); q0.delete();
      last1 = '0;  last0 = '0;
    end else begin
      if (po1) void'(q1.pop_front());
      if (pu1) q1.push_back(in_data);
      if (po0) void'(q0.pop_front());
      if (pu0) q0.push_back(in_data);
      if (q1.size() > 0) last1 = q1[0];
      if (q0.size() > 0) last0 = q0[0];
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    last1 = '0; last0 = '0;

    // 1: reset held two cycles with in_valid high
    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_count",     {30'd0, count1}, 32'd0);
    chk("rst_out_data",  out_data1, 32'd0);
    chk("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
    chk("rst_in_ready0", {31'd0, in_ready0}, 32'd1);
    step();

    // 2: streaming, one beat per cycle in both modes
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 1'b1);
      step();
      chk("stream_data1", out_data1, i);
      chk("stream_data0", out_data0, i);
    end
    drive(1'b0, '0, 1'b1);
    step();

    // 3: backpressure on the skid buffer
    drive(1'b1, 32'hA, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    chk("bp_count", {30'd0, count1}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready1}, 32'd0);
    drive(1'b0, '0, 1'b1);
    chk("bp_first", out_data1, 32'hA);
    step();
    chk("bp_second", out_data1, 32'hB);
    chk("bp_ready_after_pop", {31'd0, in_ready1}, 32'd1);
    step();
    chk("bp_drained", {31'd0, out_valid1}, 32'd0);

    // 4: flush with a full skid buffer and an incoming beat
    drive(1'b1, 32'h1, 1'b0);
    step();
    drive(1'b1, 32'h2, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'hC, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk("fl_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("fl_count",     {30'd0, count1}, 32'd0);
    chk("fl_out_data",  out_data1, 32'd0);
    step();
    step();

    // 5: hold freezes a presented beat
    drive(1'b1, 32'h5, 1'b0);
    step();
    hold = 1'b1;
    drive(1'b1, 32'h9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_data",     out_data1, 32'h5);
      chk("hold_in_ready", {31'd0, in_ready1}, 32'd0);
      chk("hold_count",    {30'd0, count1}, 32'd1);
      step();
    end
    hold = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk("hold_release_data", out_data1, 32'h5);
    step();
    chk("hold_popped", {31'd0, out_valid1}, 32'd0);

    // 6: push and pop together at count=1
    drive(1'b1, 32'h1, 1'b0);
    step();
    drive(1'b1, 32'h2, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    chk("pp_data1",  out_data1, 32'h2);
    chk("pp_count1", {30'd0, count1}, 32'd1);
    chk("pp_data0",  out_data0, 32'h2);
    chk("pp_count0", {30'd0, count0}, 32'd1);
    step();

    // Random soak against the FIFO model
    for (int i = 0; i < 3000; i++) begin
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 9) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
